decim30_iq: RTL and testbench
=============================

# decim30_iq

Complex decimate-by-N stage directly downstream of the baseband low-pass filter, replacing the testbench-only down-sampling with real hardware. Accepts one filtered 62-bit I/Q sample per `in_valid` cycle, keeps one in every DECIM, and narrows it to OUT_W bits. Buffers decimated samples in a 2-entry FIFO behind a valid/ready output so a stalling consumer never back-pressures the filter.

## Interface
- `IN_W`, 62, input sample width per component (signed)
- `OUT_W`, 32, output sample width per component (signed); must be < IN_W
- `DECIM`, 30, decimation factor; must be ≥ 2
- `PHASE`, 0, index within each group of DECIM kept; 0 ≤ PHASE < DECIM

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  input sample strobe
- `phase_sync`  in  1  qualified by in_valid; this sample is index 0
- `in_real`  in  IN_W  signed filtered I
- `in_imag`  in  IN_W  signed filtered Q
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  consumer accepts head
- `out_real`  out  OUT_W  signed decimated I
- `out_imag`  out  OUT_W  signed decimated Q
- `drop_sticky`  out  1  set when a decimated sample was lost to a full FIFO

## Operation
- Phase counter `idx`, range 0..DECIM-1, advances only on in_valid. On DECIM-1 it wraps to 0.
- An input sample is kept when its effective index equals PHASE.
  - The effective index is 0 if phase_sync=1, otherwise `idx`.
  - After a kept or non-kept sample, `idx` becomes effective index + 1, with wrap.
- Narrowing, per component: drop SH = IN_W-OUT_W LSBs.
  - Without rounding: result = in[IN_W-1:SH].
  - The MSB overflow guard exists only in the rounding path (see Configuration).
- A kept sample is pushed into the 2-entry FIFO. out_* always show the FIFO head.
  - Contents of non-valid entries are don't-care, but out_* must be 0 whenever out_valid=0.
- Pop when out_valid && out_ready.
- Push when full and no pop in the same cycle:
  - The new sample is discarded and the FIFO is unchanged.
  - drop_sticky is set and stays at 1 until reset.
- Push and pop in the same cycle, any occupancy including full: both happen and nothing is dropped.
- in_valid=0: no state changes except output pops.
- Reset asserted (any time, mid-group or with FIFO full):
  - idx=0, FIFO emptied, drop_sticky=0.
  - out_valid=0 and out_real=out_imag=0, all immediately (asynchronous).

## Timing
- Latency: a kept sample accepted at edge k is visible with out_valid=1 after edge k+1 (one register stage for narrowing, then FIFO write). With an empty FIFO this means one cycle of latency from in_valid to out_valid.
- Throughput: at most one kept sample per DECIM inputs.
  - The FIFO drains one per cycle, so it overflows only if out_ready stays low across ≥2 additional kept samples.
- out_valid and out_* are stable while out_valid && !out_ready.
- drop_sticky rises on the edge at which the discard occurs.
- Reset release is synchronised internally (2-flop deassertion synchroniser); the first input can be accepted on the 3rd edge after release.
  - Inputs before that point are ignored and do not advance idx.

## Configuration
- `DECIM30_IQ_ROUND_EN` defined:
  - Round half-up: add 1<<(SH-1) in IN_W+1 bits before shifting.
  - If the result exceeds the OUT_W positive range, saturate to 2^(OUT_W-1)-1.
  - Negative results cannot overflow.
  - The narrowing stage still adds exactly one cycle.
- Not defined: plain truncation (floor) as above; no adder, no saturation logic.

## Structure
- Package `decim_pkg` holds:
  - Default constants `DECIM_IN_W=62`, `DECIM_OUT_W=32`, `DECIM_FACTOR=30`.
  - `typedef struct packed { logic signed [OUT_W-1:0] re, im; } iq_out_t` for the default widths.
  - The function that computes SH.
- One sub-module, `decim_fifo2`:
  - Parameterised 2-entry synchronous FIFO with push/pop/full/empty and head output.
  - Same clk/reset.

## Test plan
- Ramp in_real=n, in_imag=-n (n=0..89), in_valid every cycle, out_ready=1, DECIM=30, PHASE=0, SH=30, inputs scaled by 2^30 -> exactly 3 outputs: re=0, 30, 60 and im=0, -30, -60, each one cycle after its input.
- Same ramp with phase_sync pulsed at n=10 -> outputs at n=0, 10, 40, 70 only.
- out_ready=0 for 100 inputs -> 2 outputs held stable and drop_sticky=1 after the 3rd kept sample. Then out_ready=1 -> the first two samples emerge in order.
- FIFO full and kept sample arriving in the same cycle as a pop -> no drop, drop_sticky stays 0, order preserved.
- Reset pulsed at n=15 with 1 entry queued -> out_valid=0 and outputs 0 immediately. The next kept sample is the 1st valid input after release.
- With `DECIM30_IQ_ROUND_EN`: in=(2^61-1) gives 2^31-1 (saturated); in=3·2^29 gives 2; in=-3·2^29 gives -1. Without it, the same inputs give 2^31-1, 1, -2.

Source files
------------

// File: rtl/decim_pkg.sv
// decim_pkg: shared constants, output sample type and shift helper for decim30_iq
package decim_pkg;
   localparam int DECIM_IN_W = 62;
   localparam int DECIM_OUT_W = 32;
   localparam int DECIM_FACTOR = 30;
   typedef struct packed {
      logic signed [DECIM_OUT_W-1:0] re;
      logic signed [DECIM_OUT_W-1:0] im;
   } iq_out_t;
   function automatic int shift_of(input int in_w, input int out_w);
      return in_w - out_w;
   endfunction
endpackage

// File: rtl/decim30_iq_if.sv
// decim30_iq_if: input sample stream and decimated valid/ready output stream
interface decim30_iq_if import decim_pkg::*; #(
   parameter int IN_W = DECIM_IN_W,
   parameter int OUT_W = DECIM_OUT_W
);
   logic in_valid;
   logic phase_sync;
   logic signed [IN_W-1:0] in_real;
   logic signed [IN_W-1:0] in_imag;
   logic out_valid;
   logic out_ready;
   logic signed [OUT_W-1:0] out_real;
   logic signed [OUT_W-1:0] out_imag;
   modport slave (
      input in_valid, phase_sync, in_real, in_imag, out_ready,
      output out_valid, out_real, out_imag
   );
   modport master (
      output in_valid, phase_sync, in_real, in_imag, out_ready,
      input out_valid, out_real, out_imag
   );
endinterface

// File: rtl/decim_fifo2.sv
// decim_fifo2: 2-entry FIFO, head in e0; head reads 0 when empty
module decim_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);
   logic [W-1:0] e0, e1;
   logic [1:0] cnt;
   logic do_pop, do_push, wr1;
   assign full = cnt == 2'd2;
   assign empty = cnt == 2'd0;
   assign head = empty ? '0 : e0;
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign wr1 = do_push && (do_pop ? full : cnt == 2'd1);
   // shift on pop, write new data into the first free slot after the pop
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= 2'd0;
         e0 <= '0;
         e1 <= '0;
      end else begin
         if (do_pop) e0 <= full ? e1 : din;
         else if (do_push && empty) e0 <= din;
         if (wr1) e1 <= din;
         cnt <= cnt + 2'(do_push) - 2'(do_pop);
      end
   end
endmodule

// File: rtl/decim30_iq.sv
// decim30_iq: complex decimate-by-DECIM with narrowing to OUT_W and 2-entry output FIFO
// Optional rounding with saturation when DECIM30_IQ_ROUND_EN is defined.
module decim30_iq import decim_pkg::*; #(
   parameter int IN_W = DECIM_IN_W,
   parameter int OUT_W = DECIM_OUT_W,
   parameter int DECIM = DECIM_FACTOR,
   parameter int PHASE = 0
) (
   input  logic           clk,
   input  logic           reset,
   decim30_iq_if.slave    s,
   output logic           drop_sticky
);
   localparam int SH = shift_of(IN_W, OUT_W);
   localparam int IW = $clog2(DECIM);
   typedef logic [IW-1:0] idx_t;
   localparam idx_t LAST = idx_t'(DECIM - 1);
   localparam idx_t PH = idx_t'(PHASE);
`ifdef DECIM30_IQ_ROUND_EN
   localparam logic [IN_W:0] HALF = (IN_W + 1)'(1) << (SH - 1);
   function automatic logic [OUT_W-1:0] narrow(input logic [IN_W-1:0] x);
      logic [IN_W:0] sum;
      sum = {x[IN_W-1], x} + HALF;
      return sum[IN_W:IN_W-1] == 2'b01 ? {1'b0, {(OUT_W - 1){1'b1}}} : sum[IN_W-1:SH];
   endfunction
`else
   function automatic logic [OUT_W-1:0] narrow(input logic [IN_W-1:0] x);
      return x[IN_W-1:SH];
   endfunction
`endif
   logic [1:0] sync;
   logic rst_n;
   idx_t idx, eff;
   logic keep, st_v, pop, full, empty;
   logic [2*OUT_W-1:0] st_d, head;
   assign rst_n = sync[1];
   assign eff = s.phase_sync ? '0 : idx;
   assign keep = s.in_valid && eff == PH;
   assign pop = !empty && s.out_ready;
   assign s.out_valid = !empty;
   assign {s.out_real, s.out_imag} = head;
   // assert immediately, release two edges after the external reset lifts
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync <= 2'b00;
      else sync <= {sync[0], 1'b1};
   end
   // phase counter restarts at the effective index of each valid input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) idx <= '0;
      else if (s.in_valid) idx <= eff == LAST ? '0 : eff + 1'b1;
   end
   // narrowing register between the kept sample and the FIFO write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_v <= 1'b0;
         st_d <= '0;
      end else begin
         st_v <= keep;
         if (keep) st_d <= {narrow(s.in_real), narrow(s.in_imag)};
      end
   end
   // a write into a full FIFO with no simultaneous pop is lost and remembered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_sticky <= 1'b0;
      else if (st_v && full && !pop) drop_sticky <= 1'b1;
   end
   decim_fifo2 #(.W(2 * OUT_W)) u_fifo (
      .clk(clk),
      .reset(rst_n),
      .push(st_v),
      .pop(pop),
      .din(st_d),
      .full(full),
      .empty(empty),
      .head(head)
   );
endmodule

// File: tb/tb_decim30_iq.sv
// tb_decim30_iq: directed and random stimulus against a queue-based reference of decim30_iq
module tb_decim30_iq;
   import decim_pkg::*;
   localparam int SH = 30;
   localparam int DEC = 30;
   localparam longint MAXP = 64'sd2147483647;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic drop_sticky;
   int total = 0;
   int bad = 0;
   iq_out_t mq[$];
   iq_out_t dlog[$];
   iq_out_t pend_d;
   logic pend, mdrop;
   int midx, rel, eff;
   logic signed [63:0] er, ei;
   decim30_iq_if bus ();
   decim30_iq dut (
      .clk(clk),
      .reset(reset),
      .s(bus),
      .drop_sticky(drop_sticky)
   );
   always #5 clk = ~clk;
   function automatic logic signed [31:0] nar(input longint v);
      longint r;
`ifdef DECIM30_IQ_ROUND_EN
      r = (v + (64'sd1 <<< (SH - 1))) >>> SH;
      if (r > MAXP) r = MAXP;
`else
      r = v >>> SH;
`endif
      return r[31:0];
   endfunction
   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask
   // reference: kept samples become visible one edge later in a 2-deep queue
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         pend = 1'b0;
         midx = 0;
         rel = 0;
         mdrop = 1'b0;
      end else begin
         if (rel >= 2) begin
            if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
            if (pend) begin
               if (mq.size() < 2) mq.push_back(pend_d);
               else mdrop = 1'b1;
            end
            pend = 1'b0;
            if (bus.in_valid) begin
               eff = bus.phase_sync ? 0 : midx;
               if (eff == 0) begin
                  pend = 1'b1;
                  pend_d.re = nar(longint'(bus.in_real));
                  pend_d.im = nar(longint'(bus.in_imag));
               end
               midx = (eff + 1) % DEC;
            end
         end
         if (rel < 3) rel++;
      end
   end
   // every cycle: outputs must match the reference queue head
   always @(negedge clk) begin
      er = mq.size() > 0 ? mq[0].re : 0;
      ei = mq.size() > 0 ? mq[0].im : 0;
      chk("out_valid", bus.out_valid, mq.size() > 0);
      chk("out_real", bus.out_real, er);
      chk("out_imag", bus.out_imag, ei);
      chk("drop_sticky", drop_sticky, mdrop);
      if (bus.out_valid && bus.out_ready) dlog.push_back({bus.out_real, bus.out_imag});
   end
   task automatic drive(input logic v, input logic ps, input longint re, input longint im, input logic rdy);
      bus.in_valid = v;
      bus.phase_sync = ps;
      bus.in_real = re[61:0];
      bus.in_imag = im[61:0];
      bus.out_ready = rdy;
      @(posedge clk);
      #1;
   endtask
   task automatic ramp(input int n, input logic ps, input logic rdy);
      drive(1'b1, ps, longint'(n) <<< SH, -(longint'(n) <<< SH), rdy);
   endtask
   task automatic idle(input int k);
      repeat (k) drive(1'b0, 1'b0, 0, 0, 1'b1);
   endtask
   task automatic do_reset();
      reset = 1'b0;
      idle(2);
      reset = 1'b1;
      idle(3);
      dlog.delete();
   endtask
   function automatic longint rnd62();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return longint'({{2{r[61]}}, r[61:0]});
   endfunction
   initial begin
      bus.in_valid = 1'b0;
      bus.phase_sync = 1'b0;
      bus.in_real = '0;
      bus.in_imag = '0;
      bus.out_ready = 1'b1;
      do_reset();
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_real", bus.out_real, 0);
      chk("rst_drop", drop_sticky, 0);
      for (int n = 0; n < 90; n++) begin
         ramp(n, 1'b0, 1'b1);
         if (n == 0) chk("lat_before", bus.out_valid, 0);
         if (n == 1) chk("lat_after", bus.out_valid, 1);
      end
      idle(3);
      chk("ramp_count", dlog.size(), 3);
      for (int i = 0; i < 3 && i < dlog.size(); i++) begin
         chk("ramp_re", dlog[i].re, 30 * i);
         chk("ramp_im", dlog[i].im, -30 * i);
      end
      do_reset();
      for (int n = 0; n < 90; n++) ramp(n, n == 10, 1'b1);
      idle(3);
      chk("sync_count", dlog.size(), 4);
      if (dlog.size() == 4) begin
         chk("sync_0", dlog[0].re, 0);
         chk("sync_1", dlog[1].re, 10);
         chk("sync_2", dlog[2].re, 40);
         chk("sync_3", dlog[3].im, -70);
      end
      do_reset();
      for (int n = 0; n < 100; n++) begin
         ramp(n, 1'b0, 1'b0);
         if (n == 60) chk("drop_early", drop_sticky, 0);
         if (n == 61) chk("drop_rise", drop_sticky, 1);
      end
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_head", bus.out_real, 0);
      idle(4);
      chk("stall_count", dlog.size(), 2);
      if (dlog.size() == 2) chk("stall_order", dlog[1].re, 30);
      chk("stall_sticky", drop_sticky, 1);
      do_reset();
      for (int n = 0; n < 71; n++) ramp(n, 1'b0, n == 61);
      chk("pushpop_drop", drop_sticky, 0);
      idle(4);
      chk("pushpop_count", dlog.size(), 3);
      if (dlog.size() == 3) begin
         chk("pushpop_1", dlog[1].re, 30);
         chk("pushpop_2", dlog[2].re, 60);
      end
      do_reset();
      for (int n = 0; n < 16; n++) ramp(n, 1'b0, 1'b0);
      chk("queued_valid", bus.out_valid, 1);
      #2 reset = 1'b0;
      #1;
      chk("async_valid", bus.out_valid, 0);
      chk("async_real", bus.out_real, 0);
      chk("async_imag", bus.out_imag, 0);
      ramp(500, 1'b0, 1'b1);
      ramp(501, 1'b0, 1'b1);
      reset = 1'b1;
      dlog.delete();
      for (int m = 100; m < 141; m++) ramp(m, 1'b0, 1'b1);
      idle(3);
      chk("rel_count", dlog.size(), 2);
      if (dlog.size() == 2) begin
         chk("rel_first", dlog[0].re, 102);
         chk("rel_second", dlog[1].re, 132);
      end
      do_reset();
      drive(1'b1, 1'b1, (64'sd1 <<< 61) - 1, 64'sd3 <<< 29, 1'b1);
      drive(1'b1, 1'b1, -(64'sd3 <<< 29), 0, 1'b1);
      idle(3);
      chk("round_count", dlog.size(), 2);
      if (dlog.size() == 2) begin
         chk("round_max", dlog[0].re, MAXP);
`ifdef DECIM30_IQ_ROUND_EN
         chk("round_pos", dlog[0].im, 2);
         chk("round_neg", dlog[1].re, -1);
`else
         chk("trunc_pos", dlog[0].im, 1);
         chk("trunc_neg", dlog[1].re, -2);
`endif
      end
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 3) != 0,
               (i % 1000 < 500) ? $urandom_range(0, 7) == 0 : $urandom_range(0, 60) == 0,
               rnd62(), rnd62(),
               (i % 400 < 150) ? $urandom_range(0, 7) == 0 : $urandom_range(0, 3) != 0);
      end
      idle(4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
